// File: rtl/regfile_wr_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// regfile_wr_arbiter_pkg
// Shared constants for the register-file write-port arbiter.
//   RF_ADDR_W / RF_DATA_W : default register index / data widths (32x32 file)
//   REG_ZERO              : hard-wired zero register; writes to it are dropped
//   GRANT_A / GRANT_B     : encoding of the last_grant priority flop
// ----------------------------------------------------------------------------
package regfile_wr_arbiter_pkg;

    localparam int RF_ADDR_W = 5;
    localparam int RF_DATA_W = 32;
    localparam int REG_ZERO  = 0;

    localparam logic GRANT_A = 1'b0;
    localparam logic GRANT_B = 1'b1;

endpackage : regfile_wr_arbiter_pkg

// File: rtl/regfile_wr_arbiter_rr_arb2.sv
// ----------------------------------------------------------------------------
// rr_arb2
// Two-input round-robin grant logic, purely combinational.
// Ports:
//   a_valid, b_valid : request lines
//   hold             : suppresses every grant while high
//   last_grant       : requester granted most recently (GRANT_A / GRANT_B)
//   grant[1:0]       : one-hot grant, bit 0 = A, bit 1 = B
// ----------------------------------------------------------------------------
module rr_arb2
    import regfile_wr_arbiter_pkg::*;
(
    input  logic       a_valid,
    input  logic       b_valid,
    input  logic       hold,
    input  logic       last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (!hold) begin
            if (a_valid && b_valid) begin
                // Contended cycle: the requester not served last wins.
                if (last_grant == GRANT_A) begin
                    grant[1] = 1'b1;
                end else begin
                    grant[0] = 1'b1;
                end
            end else if (a_valid) begin
                grant[0] = 1'b1;
            end else if (b_valid) begin
                grant[1] = 1'b1;
            end
        end
    end

endmodule : rr_arb2

// File: rtl/regfile_wr_arbiter.sv
// ----------------------------------------------------------------------------
// regfile_wr_arbiter
// Shares the single write port of the register file between the ALU
// writeback (A) and the load writeback (B) with round-robin priority.
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   a_valid/a_addr/a_data    : requester A write request
//   a_ready                  : A accepted this cycle (combinational)
//   b_valid/b_addr/b_data    : requester B write request
//   b_ready                  : B accepted this cycle (combinational)
//   hold                     : register file port unavailable, no grants
//   wr_en/wr_addr/wr_data    : registered write into the register array
//   conflict_cnt             : saturating count of cycles with both valid
//   last_grant               : 0 = A granted last, 1 = B granted last
// ----------------------------------------------------------------------------
module regfile_wr_arbiter
    import regfile_wr_arbiter_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    input  logic              hold,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [CNT_W-1:0]  conflict_cnt,
    output logic              last_grant
);

    logic [1:0]        grant;
    logic              xfer;
    logic              sel_b;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
    logic              wr_en_next;

    rr_arb2 u_rr_arb2 (
        .a_valid    (a_valid),
        .b_valid    (b_valid),
        .hold       (hold),
        .last_grant (last_grant),
        .grant      (grant)
    );

    // Grants are masked during reset so nothing is accepted that the
    // cleared output register could not carry.
    assign a_ready = grant[0] & ~rst;
    assign b_ready = grant[1] & ~rst;

    // grant already includes valid, so ready alone marks a transfer.
    assign xfer     = a_ready | b_ready;
    assign sel_b    = b_ready;
    assign sel_addr = sel_b ? b_addr : a_addr;
    assign sel_data = sel_b ? b_data : a_data;

    // A transfer to the zero register is accepted but never written.
    assign wr_en_next = xfer && (sel_addr != ADDR_W'(REG_ZERO));

    // Output register: enable every cycle, address/data only on a real write
    // so a dropped zero-register transfer leaves them untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            wr_en <= wr_en_next;
            if (wr_en_next) begin
                wr_addr <= sel_addr;
                wr_data <= sel_data;
            end
        end
    end

    // Reset to GRANT_B so that A holds priority on the first contention.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= GRANT_B;
        end else if (xfer) begin
            last_grant <= sel_b ? GRANT_B : GRANT_A;
        end
    end

    // Counts contention independently of hold; sticks at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conflict_cnt <= '0;
        end else if (a_valid && b_valid && (conflict_cnt != {CNT_W{1'b1}})) begin
            conflict_cnt <= conflict_cnt + 1'b1;
        end
    end

endmodule : regfile_wr_arbiter

// File: tb/tb_regfile_wr_arbiter.sv
// ----------------------------------------------------------------------------
// tb_regfile_wr_arbiter
// Directed bench for regfile_wr_arbiter (CNT_W = 4 build so saturation is
// reachable quickly). Inputs change 1 time unit after a rising edge; ready
// is sampled 1 unit later, registered outputs 1 unit after the next edge.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_regfile_wr_arbiter;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              a_valid;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_data;
    logic              a_ready;
    logic              b_valid;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_data;
    logic              b_ready;
    logic              hold;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [CNT_W-1:0]  conflict_cnt;
    logic              last_grant;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    regfile_wr_arbiter #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .a_valid      (a_valid),
        .a_addr       (a_addr),
        .a_data       (a_data),
        .a_ready      (a_ready),
        .b_valid      (b_valid),
        .b_addr       (b_addr),
        .b_data       (b_data),
        .b_ready      (b_ready),
        .hold         (hold),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .conflict_cnt (conflict_cnt),
        .last_grant   (last_grant)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) begin
            pass_cnt++;
            $display("ok   %-22s got=0x%08h", tag, got);
        end else begin
            $display("FAIL %-22s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic set_in(input logic av, input logic [ADDR_W-1:0] aa, input logic [DATA_W-1:0] ad,
                          input logic bv, input logic [ADDR_W-1:0] ba, input logic [DATA_W-1:0] bd,
                          input logic h);
        a_valid = av; a_addr = aa; a_data = ad;
        b_valid = bv; b_addr = ba; b_data = bd;
        hold    = h;
    endtask

    // Advance to 1 unit after the next rising edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        set_in(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        // ---------------- reset state ----------------
        rst = 1'b1;
        set_in(1'b1, 5'd3, 32'hDEADBEEF, 1'b1, 5'd4, 32'h1234, 1'b0);
        cycle();
        cycle();
        check("rst_a_ready", a_ready, 0);
        check("rst_b_ready", b_ready, 0);
        check("rst_wr_en", wr_en, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_cnt", conflict_cnt, 0);
        check("rst_last_grant", last_grant, 1);

        // ---------------- A alone after reset release ----------------
        rst = 1'b0;
        set_in(1'b1, 5'd3, 32'hDEADBEEF, 1'b0, '0, '0, 1'b0);
        #1;
        check("a_alone_a_ready", a_ready, 1);
        check("a_alone_b_ready", b_ready, 0);
        cycle();
        check("a_alone_wr_en", wr_en, 1);
        check("a_alone_wr_addr", wr_addr, 3);
        check("a_alone_wr_data", wr_data, 32'hDEADBEEF);
        check("a_alone_last_grant", last_grant, 0);
        set_in(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
        cycle();
        check("idle_wr_en", wr_en, 0);
        check("idle_wr_addr_kept", wr_addr, 3);

        // ---------------- both valid: A,B,A,B ----------------
        reset_dut();
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, 5'd5, 32'h1, 1'b1, 5'd6, 32'h2, 1'b0);
            #1;
            check($sformatf("rr%0d_a_ready", i), a_ready, (i % 2 == 0) ? 1 : 0);
            check($sformatf("rr%0d_b_ready", i), b_ready, (i % 2 == 0) ? 0 : 1);
            cycle();
            check($sformatf("rr%0d_wr_en", i), wr_en, 1);
            check($sformatf("rr%0d_wr_addr", i), wr_addr, (i % 2 == 0) ? 5 : 6);
            check($sformatf("rr%0d_wr_data", i), wr_data, (i % 2 == 0) ? 1 : 2);
        end
        check("rr_cnt", conflict_cnt, 4);
        check("rr_last_grant", last_grant, 1);

        // ---------------- hold with both valid ----------------
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 5'd5, 32'h1, 1'b1, 5'd6, 32'h2, 1'b1);
            #1;
            check($sformatf("hold%0d_a_ready", i), a_ready, 0);
            check($sformatf("hold%0d_b_ready", i), b_ready, 0);
            cycle();
            check($sformatf("hold%0d_wr_en", i), wr_en, 0);
            check($sformatf("hold%0d_last_grant", i), last_grant, 1);
        end
        check("hold_cnt", conflict_cnt, 7);
        set_in(1'b1, 5'd5, 32'h1, 1'b1, 5'd6, 32'h2, 1'b0);
        #1;
        check("unhold_a_ready", a_ready, 1);
        check("unhold_b_ready", b_ready, 0);
        cycle();
        check("unhold_wr_addr", wr_addr, 5);
        check("unhold_last_grant", last_grant, 0);
        check("unhold_cnt", conflict_cnt, 8);

        // ---------------- B write to register 0 ----------------
        set_in(1'b0, '0, '0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b0);
        #1;
        check("r0_b_ready", b_ready, 1);
        cycle();
        check("r0_wr_en", wr_en, 0);
        check("r0_wr_addr_kept", wr_addr, 5);
        check("r0_wr_data_kept", wr_data, 1);
        check("r0_last_grant", last_grant, 1);
        check("r0_cnt", conflict_cnt, 8);

        // ---------------- counter saturation ----------------
        for (int i = 0; i < 20; i++) begin
            set_in(1'b1, 5'd5, 32'h1, 1'b1, 5'd6, 32'h2, 1'b1);
            cycle();
        end
        check("sat_cnt", conflict_cnt, 15);
        check("sat_wr_en", wr_en, 0);

        // ---------------- same address, grant order ----------------
        reset_dut();
        set_in(1'b1, 5'd7, 32'hA, 1'b1, 5'd7, 32'hB, 1'b0);
        #1;
        check("same_a_ready", a_ready, 1);
        cycle();
        check("same1_wr_data", wr_data, 32'hA);
        set_in(1'b0, '0, '0, 1'b1, 5'd7, 32'hB, 1'b0);
        #1;
        check("same_b_ready", b_ready, 1);
        cycle();
        check("same2_wr_addr", wr_addr, 7);
        check("same2_wr_data", wr_data, 32'hB);
        check("same_cnt", conflict_cnt, 1);

        // ---------------- back-to-back A ----------------
        for (int i = 1; i <= 3; i++) begin
            set_in(1'b1, 5'(i + 10), 32'h100 + 32'(i), 1'b0, '0, '0, 1'b0);
            #1;
            check($sformatf("b2b%0d_a_ready", i), a_ready, 1);
            cycle();
            check($sformatf("b2b%0d_wr_en", i), wr_en, 1);
            check($sformatf("b2b%0d_wr_addr", i), wr_addr, i + 10);
            check($sformatf("b2b%0d_wr_data", i), wr_data, 32'h100 + 32'(i));
        end

        // ---------------- reset mid-operation ----------------
        set_in(1'b1, 5'd9, 32'h55, 1'b0, '0, '0, 1'b0);
        cycle();
        check("mid_pre_wr_en", wr_en, 1);
        rst = 1'b1;
        #1;
        check("mid_wr_en", wr_en, 0);
        check("mid_wr_addr", wr_addr, 0);
        check("mid_wr_data", wr_data, 0);
        check("mid_last_grant", last_grant, 1);
        check("mid_cnt", conflict_cnt, 0);
        check("mid_a_ready", a_ready, 0);
        cycle();
        rst = 1'b0;
        set_in(1'b1, 5'd2, 32'h22, 1'b1, 5'd3, 32'h33, 1'b0);
        #1;
        check("post_a_ready", a_ready, 1);
        check("post_b_ready", b_ready, 0);
        cycle();
        check("post_wr_addr", wr_addr, 2);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule : tb_regfile_wr_arbiter
